// File: rtl/pipe_adder_pkg.sv
// Shared arithmetic helpers for the MIPS datapath: chunk sizing, parameter
// sanity check and the per-stage flag bundle carried down the adder pipe.
package mips_arith_pkg;

    function automatic int chunk_w(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

    function automatic bit split_ok(input int width, input int stages);
        return (stages >= 1) && (width % stages == 0);
    endfunction

    typedef struct packed {
        logic valid;
        logic carry;
        logic a_msb;
        logic b_msb;
    } stage_flags_t;

endpackage

// File: rtl/pipe_adder_chunk.sv
// One carry-chain segment: CW-bit a + b + cin with carry out.
module adder_chunk #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] s,
    output logic          cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor: the carry chain is split into STAGES registered
// chunks with a valid/ready handshake whose ready chain collapses bubbles.
module pipe_adder
    import mips_arith_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = chunk_w(WIDTH, STAGES);

    if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
        $error("pipe_adder: STAGES must be >= 1 and divide WIDTH");
    end

    logic         [STAGES-1:0]            stage_valid;
    logic         [STAGES-1:0]            load;
    stage_flags_t [STAGES-1:0]            flags_q;
    logic         [STAGES-1:0][WIDTH-1:0] a_q;
    logic         [STAGES-1:0][WIDTH-1:0] b_q;
    logic         [STAGES-1:0][WIDTH-1:0] res_q;

    always_comb begin
        stage_valid = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            stage_valid[i] = flags_q[i].valid;
        end
    end

    // Unrolled form of load[k] = !v[k] || load[k+1]: a stage may load when the
    // consumer is ready or any stage at or after it holds a bubble.
    always_comb begin
        load = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            load[i] = out_ready;
            for (int unsigned j = i; j < STAGES; j++) begin
                if (!stage_valid[j]) begin
                    load[i] = 1'b1;
                end
            end
        end
    end

    assign in_ready = load[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] res_in;
        logic [WIDTH-1:0] res_next;
        logic             cin;
        logic             v_in;
        logic             a_msb_in;
        logic             b_msb_in;
        logic [CW-1:0]    chunk_s;
        logic             chunk_c;

        if (k == 0) begin : g_head
            assign a_in     = a;
            assign b_in     = sub ? ~b : b;
            assign res_in   = '0;
            assign cin      = sub;
            assign v_in     = in_valid;
            assign a_msb_in = a[WIDTH-1];
            assign b_msb_in = b_in[WIDTH-1];
        end else begin : g_body
            assign a_in     = a_q[k-1];
            assign b_in     = b_q[k-1];
            assign res_in   = res_q[k-1];
            assign cin      = flags_q[k-1].carry;
            assign v_in     = flags_q[k-1].valid;
            assign a_msb_in = flags_q[k-1].a_msb;
            assign b_msb_in = flags_q[k-1].b_msb;
        end

        adder_chunk #(
            .CW(CW)
        ) u_chunk (
            .a   (a_in[k*CW +: CW]),
            .b   (b_in[k*CW +: CW]),
            .cin (cin),
            .s   (chunk_s),
            .cout(chunk_c)
        );

        always_comb begin
            res_next               = res_in;
            res_next[k*CW +: CW]   = chunk_s;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                flags_q[k] <= '0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                res_q[k]   <= '0;
            end else if (load[k]) begin
                flags_q[k].valid <= v_in;
                flags_q[k].carry <= chunk_c;
                flags_q[k].a_msb <= a_msb_in;
                flags_q[k].b_msb <= b_msb_in;
                a_q[k]           <= a_in;
                b_q[k]           <= b_in;
                res_q[k]         <= res_next;
            end
        end
    end

    // Already-consumed low chunks and the last stage's operand copy are dead.
    logic unused_skew_bits;
    assign unused_skew_bits = ^{a_q, b_q};

    assign out_valid = flags_q[STAGES-1].valid;
    assign sum       = res_q[STAGES-1];
    assign carry_out = flags_q[STAGES-1].carry;
    assign overflow  = (flags_q[STAGES-1].a_msb == flags_q[STAGES-1].b_msb) &&
                       (sum[WIDTH-1] != flags_q[STAGES-1].a_msb);

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: directed vectors, randomized stalled
// stream against a queue model, reset flush and a small parameter sweep.
module tb_pipe_adder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        carry_out;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    pipe_adder #(.WIDTH(32), .STAGES(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out), .overflow(overflow)
    );

    // Sweep instances share one stimulus set.
    logic        sw_in_valid;
    logic [31:0] sw_a32;
    logic [31:0] sw_b32;
    logic [63:0] sw_a64;
    logic [63:0] sw_b64;
    logic        sw_sub;
    logic        sw_out_ready;

    logic        s1_in_ready, s1_out_valid, s1_carry, s1_ovf;
    logic [31:0] s1_sum;
    logic        s8_in_ready, s8_out_valid, s8_carry, s8_ovf;
    logic [31:0] s8_sum;
    logic        w64_in_ready, w64_out_valid, w64_carry, w64_ovf;
    logic [63:0] w64_sum;

    pipe_adder #(.WIDTH(32), .STAGES(1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(s1_in_ready),
        .a(sw_a32), .b(sw_b32), .sub(sw_sub), .out_valid(s1_out_valid),
        .out_ready(sw_out_ready), .sum(s1_sum), .carry_out(s1_carry), .overflow(s1_ovf)
    );

    pipe_adder #(.WIDTH(32), .STAGES(8)) u_s8 (
        .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(s8_in_ready),
        .a(sw_a32), .b(sw_b32), .sub(sw_sub), .out_valid(s8_out_valid),
        .out_ready(sw_out_ready), .sum(s8_sum), .carry_out(s8_carry), .overflow(s8_ovf)
    );

    pipe_adder #(.WIDTH(64), .STAGES(4)) u_w64 (
        .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(w64_in_ready),
        .a(sw_a64), .b(sw_b64), .sub(sw_sub), .out_valid(w64_out_valid),
        .out_ready(sw_out_ready), .sum(w64_sum), .carry_out(w64_carry), .overflow(w64_ovf)
    );

    // Reference result packed as {overflow, carry, sum}, from signed/unsigned arithmetic.
    function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                            input logic s);
        longint      sx;
        longint      sy;
        longint      r;
        logic [31:0] res;
        logic        c;
        logic        v;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        r   = s ? (sx - sy) : (sx + sy);
        res = s ? (x - y) : (x + y);
        c   = s ? (x >= y) : ((x + y) < x);
        v   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        return {v, c, res};
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 32'h1234_5678;
        b         = 32'h0000_0001;
        sub       = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (sum !== 32'h0) begin errors++; $display("FAIL reset_sum: got %h expected 0", sum); end
        checks++;
        if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", carry_out); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        for (int i = 0; i < 6; i++) begin
            tick();
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_beat_leak: out_valid got %b expected 0 at cycle %0d", out_valid, i);
            end
        end
    endtask

    task automatic test_directed;
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic        vs [4];
        logic [33:0] exp_r;
        int          lat;
        va[0] = 32'h0000_0001; vb[0] = 32'hFFFF_FFFF; vs[0] = 1'b0;
        va[1] = 32'h7FFF_FFFF; vb[1] = 32'h0000_0001; vs[1] = 1'b0;
        va[2] = 32'h8000_0000; vb[2] = 32'h0000_0001; vs[2] = 1'b1;
        va[3] = 32'h0000_0005; vb[3] = 32'h0000_0007; vs[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a         = va[i];
            b         = vb[i];
            sub       = vs[i];
            in_valid  = 1'b1;
            out_ready = 1'b1;
            exp_r     = ref_add(va[i], vb[i], vs[i]);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL directed_in_ready[%0d]: got %b expected 1", i, in_ready); end
            tick();
            in_valid = 1'b0;
            lat      = 1;
            #1;
            while (!out_valid && lat < 20) begin
                tick();
                #1;
                lat++;
            end
            checks++;
            if (lat != 4) begin errors++; $display("FAIL directed_latency[%0d]: got %0d expected 4", i, lat); end
            checks++;
            if (sum !== exp_r[31:0]) begin errors++; $display("FAIL directed_sum[%0d]: got %h expected %h", i, sum, exp_r[31:0]); end
            checks++;
            if (carry_out !== exp_r[32]) begin errors++; $display("FAIL directed_carry[%0d]: got %b expected %b", i, carry_out, exp_r[32]); end
            checks++;
            if (overflow !== exp_r[33]) begin errors++; $display("FAIL directed_overflow[%0d]: got %b expected %b", i, overflow, exp_r[33]); end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        logic [33:0] q[$];
        logic [33:0] exp_r;
        logic [33:0] held;
        logic        exp_ready;
        bit          stalled;
        int          sent;
        int          got;
        int          cyc;
        sent    = 0;
        got     = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        while (got < 16 && cyc < 400) begin
            in_valid  = (sent < 16);
            a         = $urandom;
            b         = $urandom;
            sub       = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            #1;
            exp_ready = (q.size() < 4) || out_ready;
            checks++;
            if (in_ready !== exp_ready) begin
                errors++;
                $display("FAIL b2b_in_ready: got %b expected %b (occupancy %0d)", in_ready, exp_ready, q.size());
            end
            if (stalled) begin
                checks++;
                if (!out_valid || {overflow, carry_out, sum} !== held) begin
                    errors++;
                    $display("FAIL b2b_stall_hold: got v=%b %h expected v=1 %h", out_valid, {overflow, carry_out, sum}, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious: got beat %h expected none", {overflow, carry_out, sum});
                end else begin
                    exp_r = q.pop_front();
                    if ({overflow, carry_out, sum} !== exp_r) begin
                        errors++;
                        $display("FAIL b2b_result[%0d]: got %h expected %h", got, {overflow, carry_out, sum}, exp_r);
                    end
                end
                got++;
            end
            stalled = out_valid && !out_ready;
            held    = {overflow, carry_out, sum};
            if (in_valid && in_ready) begin
                q.push_back(ref_add(a, b, sub));
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 16) begin errors++; $display("FAIL b2b_timeout: got %0d beats expected 16", got); end
    endtask

    task automatic test_reset_flush;
        bit leaked;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = $urandom;
            b        = $urandom;
            sub      = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
        checks++;
        if ({overflow, carry_out, sum} !== 34'h0) begin
            errors++;
            $display("FAIL flush_outputs: got %h expected 0", {overflow, carry_out, sum});
        end
        leaked = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            if (out_valid) leaked = 1'b1;
        end
        checks++;
        if (leaked) begin errors++; $display("FAIL flush_leak: got out_valid=1 expected 0 after reset"); end
    endtask

    task automatic test_sweep;
        int lat1;
        int lat8;
        int lat64;
        logic [31:0] sum1, sum8;
        logic [63:0] sum64;
        logic c1, c8, c64;
        lat1 = 0; lat8 = 0; lat64 = 0;
        sum1 = '1; sum8 = '1; sum64 = '1;
        c1 = 1'b0; c8 = 1'b0; c64 = 1'b0;
        sw_a32       = '1;
        sw_b32       = 32'd1;
        sw_a64       = '1;
        sw_b64       = 64'd1;
        sw_sub       = 1'b0;
        sw_out_ready = 1'b1;
        sw_in_valid  = 1'b1;
        #1;
        checks++;
        if ({s1_in_ready, s8_in_ready, w64_in_ready} !== 3'b111) begin
            errors++;
            $display("FAIL sweep_in_ready: got %b expected 111", {s1_in_ready, s8_in_ready, w64_in_ready});
        end
        tick();
        sw_in_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            #1;
            if (s1_out_valid && lat1 == 0) begin lat1 = c; sum1 = s1_sum; c1 = s1_carry; end
            if (s8_out_valid && lat8 == 0) begin lat8 = c; sum8 = s8_sum; c8 = s8_carry; end
            if (w64_out_valid && lat64 == 0) begin lat64 = c; sum64 = w64_sum; c64 = w64_carry; end
            tick();
        end
        checks++;
        if (lat1 != 1) begin errors++; $display("FAIL sweep_s1_latency: got %0d expected 1", lat1); end
        checks++;
        if (sum1 !== 32'h0 || c1 !== 1'b1) begin errors++; $display("FAIL sweep_s1_result: got sum=%h c=%b expected sum=0 c=1", sum1, c1); end
        checks++;
        if (lat8 != 8) begin errors++; $display("FAIL sweep_s8_latency: got %0d expected 8", lat8); end
        checks++;
        if (sum8 !== 32'h0 || c8 !== 1'b1) begin errors++; $display("FAIL sweep_s8_result: got sum=%h c=%b expected sum=0 c=1", sum8, c8); end
        checks++;
        if (lat64 != 4) begin errors++; $display("FAIL sweep_w64_latency: got %0d expected 4", lat64); end
        checks++;
        if (sum64 !== 64'h0 || c64 !== 1'b1) begin errors++; $display("FAIL sweep_w64_result: got sum=%h c=%b expected sum=0 c=1", sum64, c64); end
        checks++;
        if ({s1_ovf, s8_ovf, w64_ovf} !== 3'b000) begin
            errors++;
            $display("FAIL sweep_overflow: got %b expected 000", {s1_ovf, s8_ovf, w64_ovf});
        end
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        a            = '0;
        b            = '0;
        sub          = 1'b0;
        out_ready    = 1'b1;
        sw_in_valid  = 1'b0;
        sw_a32       = '0;
        sw_b32       = '0;
        sw_a64       = '0;
        sw_b64       = '0;
        sw_sub       = 1'b0;
        sw_out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_flush();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
